// File: rtl/fabric_pkg.sv
// Shared constants and types for the fabric memory responder: region bases,
// bank geometry, FSM states and the per-port request bundle.
package fabric_pkg;
  localparam logic [31:0] ADDR_MAP  = 32'h4000_0000;
  localparam logic [31:0] ADDR_DIR  = 32'h4000_2000;
  localparam int          MAP_WORDS = 128;
  localparam int          NODES     = 1024;
  localparam int          IDX_W     = $clog2(MAP_WORDS);
  localparam int          NIB_W     = 4;
  localparam int          DIR_W     = 3;

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Keeps only the low DIR_W bits of every nibble-wide direction slot.
  function automatic logic [31:0] dir_mask();
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 32 / NIB_W; k++)
      m[k*NIB_W +: NIB_W] = NIB_W'((1 << DIR_W) - 1);
    return m;
  endfunction
endpackage

// File: rtl/fabric_mem_bank.sv
// 128x32 word RAM: synchronous write, registered read that holds its value
// until the next read enable.
module fabric_mem_bank #(
  parameter int DEPTH = 128,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata     <= mem[addr];
  end
endmodule

// File: rtl/fabric_mem_resp.sv
// Memory-side responder for fabric word transactions, with a lower-priority
// host port sharing the map and direction banks.
module fabric_mem_resp #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ADDR_MAP    = 32'h4000_0000,
  parameter logic [31:0] ADDR_DIR    = 32'h4000_2000
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        txn_req,
  input  logic        txn_wr,
  input  logic [31:0] txn_addr,
  input  logic [31:0] txn_wdata,
  output logic [31:0] txn_rdata,
  output logic        txn_rdy,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_rdy,
  output logic        err
);
  import fabric_pkg::*;

  localparam logic [3:0] WAIT_LD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e           state;
  logic [3:0]       wcnt;
  logic             own_fab, rd_map, rd_dir, err_q;
  logic             open_slot, take_fab, take_host, accept;
  logic             hit_map, hit_dir, dec_err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      map_q, dir_q, rdata_mux;
  req_t             cur;

  // The accepting cycle is the request cycle itself, so rdy lands at T+1+WAIT.
  // A host that is being answered still holds host_req; don't re-take it.
  assign open_slot = (state == S_IDLE) || (state == S_RESP);
  assign take_fab  = open_slot && txn_req;
  assign take_host = open_slot && !txn_req && host_req && !(state == S_RESP && !own_fab);
  assign accept    = take_fab || take_host;

  always_comb begin
    cur = take_fab ? '{wr: txn_wr,  addr: txn_addr,  wdata: txn_wdata}
                   : '{wr: host_wr, addr: host_addr, wdata: host_wdata};
  end

  assign hit_map = (cur.addr[31:9] == ADDR_MAP[31:9]) && (cur.addr[1:0] == 2'b00);
  assign hit_dir = !hit_map && (cur.addr[31:9] == ADDR_DIR[31:9]) && (cur.addr[1:0] == 2'b00);
  assign dec_err = !hit_map && !hit_dir;
  assign idx     = cur.addr[IDX_W+1:2];

  fabric_mem_bank #(.DEPTH(MAP_WORDS), .W(32)) u_map (
    .clk(clk), .we(accept && cur.wr && hit_map), .re(accept && !cur.wr && hit_map),
    .addr(idx), .wdata(cur.wdata), .rdata(map_q)
  );

  fabric_mem_bank #(.DEPTH(MAP_WORDS), .W(32)) u_dir (
    .clk(clk), .we(accept && cur.wr && hit_dir), .re(accept && !cur.wr && hit_dir),
    .addr(idx), .wdata(cur.wdata & dir_mask()), .rdata(dir_q)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      own_fab <= 1'b0;
      rd_map  <= 1'b0;
      rd_dir  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if ((accept && dec_err) || (txn_req && state == S_WAIT)) err_q <= 1'b1;
      if (accept) begin
        own_fab <= take_fab;
        rd_map  <= !cur.wr && hit_map;
        rd_dir  <= !cur.wr && hit_dir;
        wcnt    <= WAIT_LD;
        state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end else begin
        case (state)
          S_WAIT:  if (wcnt == 4'd0) state <= S_RESP;
                   else              wcnt  <= wcnt - 4'd1;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rdata_mux  = rd_map ? map_q : (rd_dir ? dir_q : 32'h0);
  assign txn_rdy    = (state == S_RESP) && own_fab;
  assign host_rdy   = (state == S_RESP) && !own_fab;
  assign txn_rdata  = txn_rdy  ? rdata_mux : 32'h0;
  assign host_rdata = host_rdy ? rdata_mux : 32'h0;
  assign err        = err_q;
endmodule

// File: tb/tb_fabric_mem_resp.sv
// Directed bench for fabric_mem_resp: three instances (WAIT_CYCLES 0, 3, 2),
// a vector table on the zero-wait instance plus multi-cycle corner sequences.
module tb_fabric_mem_resp;
  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        arst;
  logic        txn_req   [ND];
  logic        txn_wr    [ND];
  logic [31:0] txn_addr  [ND];
  logic [31:0] txn_wdata [ND];
  logic [31:0] txn_rdata [ND];
  logic        txn_rdy   [ND];
  logic        host_req  [ND];
  logic        host_wr   [ND];
  logic [31:0] host_addr [ND];
  logic [31:0] host_wdata[ND];
  logic [31:0] host_rdata[ND];
  logic        host_rdy  [ND];
  logic        err       [ND];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    fabric_mem_resp #(.WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 2))) u_dut (
      .clk(clk), .arst(arst),
      .txn_req(txn_req[g]), .txn_wr(txn_wr[g]), .txn_addr(txn_addr[g]),
      .txn_wdata(txn_wdata[g]), .txn_rdata(txn_rdata[g]), .txn_rdy(txn_rdy[g]),
      .host_req(host_req[g]), .host_wr(host_wr[g]), .host_addr(host_addr[g]),
      .host_wdata(host_wdata[g]), .host_rdata(host_rdata[g]), .host_rdy(host_rdy[g]),
      .err(err[g])
    );
  end

  typedef struct {
    bit          host;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      txn_req[d] = 1'b0;  txn_wr[d] = 1'b0;  txn_addr[d] = '0;  txn_wdata[d] = '0;
      host_req[d] = 1'b0; host_wr[d] = 1'b0; host_addr[d] = '0; host_wdata[d] = '0;
    end
  endtask

  task automatic fab(input int d, input bit wr, input logic [31:0] a, input logic [31:0] w);
    txn_req[d] = 1'b1; txn_wr[d] = wr; txn_addr[d] = a; txn_wdata[d] = w;
  endtask

  task automatic host(input int d, input bit wr, input logic [31:0] a, input logic [31:0] w);
    host_req[d] = 1'b1; host_wr[d] = wr; host_addr[d] = a; host_wdata[d] = w;
  endtask

  // Hold host_req until host_rdy (bounded), capture data, return to idle.
  task automatic host_xfer(input int d, input bit wr, input logic [31:0] a,
                           input logic [31:0] w, output logic [31:0] rd, output bit ok);
    host(d, wr, a, w);
    ok = 1'b0;
    rd = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (host_rdy[d]) begin
        ok = 1'b1;
        rd = host_rdata[d];
      end
    end
    host_req[d] = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] rd;
    bit          ok;

    tbl[0]  = '{1, 1, 32'h4000_0000, 32'h7654_3210, 32'h0,         0};
    tbl[1]  = '{0, 0, 32'h4000_0000, 32'h0,         32'h7654_3210, 0};
    tbl[2]  = '{1, 1, 32'h4000_0004, 32'hFEDC_BA98, 32'h0,         0};
    tbl[3]  = '{0, 0, 32'h4000_0004, 32'h0,         32'hFEDC_BA98, 0};
    tbl[4]  = '{0, 1, 32'h4000_01FC, 32'hA5A5_A5A5, 32'h0,         0};
    tbl[5]  = '{1, 0, 32'h4000_01FC, 32'h0,         32'hA5A5_A5A5, 0};
    tbl[6]  = '{0, 1, 32'h4000_2004, 32'h0123_4567, 32'h0,         0};
    tbl[7]  = '{1, 0, 32'h4000_2004, 32'h0,         32'h0123_4567, 0};
    tbl[8]  = '{0, 1, 32'h4000_0000, 32'h1111_1111, 32'h0,         0};
    tbl[9]  = '{0, 0, 32'h4000_0000, 32'h0,         32'h1111_1111, 0};
    tbl[10] = '{1, 1, 32'h4000_0000, 32'h7654_3210, 32'h0,         0};
    tbl[11] = '{0, 0, 32'h4000_1000, 32'h0,         32'h0,         1};
    tbl[12] = '{1, 0, 32'h4000_0002, 32'h0,         32'h0,         1};
    tbl[13] = '{0, 0, 32'h4000_0200, 32'h0,         32'h0,         1};

    idle_all();
    arst = 1'b1;
    step();
    step();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst%0d txn_rdy", d),    txn_rdy[d],    0);
      chk($sformatf("rst%0d host_rdy", d),   host_rdy[d],   0);
      chk($sformatf("rst%0d txn_rdata", d),  txn_rdata[d],  0);
      chk($sformatf("rst%0d host_rdata", d), host_rdata[d], 0);
      chk($sformatf("rst%0d err", d),        err[d],        0);
    end
    arst = 1'b0;
    step();

    // Single transactions on the zero-wait instance.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].host) host(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      else             fab(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      step();
      txn_req[0] = 1'b0;
      host_req[0] = 1'b0;
      chk($sformatf("v%0d rdy", i),   tbl[i].host ? host_rdy[0] : txn_rdy[0], 1);
      chk($sformatf("v%0d other", i), tbl[i].host ? txn_rdy[0] : host_rdy[0], 0);
      chk($sformatf("v%0d rdata", i), tbl[i].host ? host_rdata[0] : txn_rdata[0], tbl[i].exp);
      chk($sformatf("v%0d err", i),   err[0], tbl[i].exp_err);
      step();
    end
    step();
    chk("err sticky", err[0], 1);
    arst = 1'b1;
    step();
    chk("err cleared", err[0], 0);
    arst = 1'b0;
    step();

    // Back-to-back fabric reads: new req in the rdy cycle.
    fab(0, 0, 32'h4000_0000, 0);
    step();
    chk("b2b rdy1", txn_rdy[0], 1);
    chk("b2b data1", txn_rdata[0], 32'h7654_3210);
    fab(0, 0, 32'h4000_0004, 0);
    step();
    txn_req[0] = 1'b0;
    chk("b2b rdy2", txn_rdy[0], 1);
    chk("b2b data2", txn_rdata[0], 32'hFEDC_BA98);
    step();
    chk("b2b idle", txn_rdy[0], 0);
    chk("b2b idle data", txn_rdata[0], 0);

    // Simultaneous fabric and host: fabric first, host two cycles after req.
    fab(0, 0, 32'h4000_01FC, 0);
    host(0, 0, 32'h4000_0000, 0);
    step();
    txn_req[0] = 1'b0;
    chk("arb txn_rdy", txn_rdy[0], 1);
    chk("arb host wait", host_rdy[0], 0);
    chk("arb txn data", txn_rdata[0], 32'hA5A5_A5A5);
    step();
    chk("arb host_rdy", host_rdy[0], 1);
    chk("arb txn quiet", txn_rdy[0], 0);
    chk("arb host data", host_rdata[0], 32'h7654_3210);
    host_req[0] = 1'b0;
    step();
    chk("arb host once", host_rdy[0], 0);
    chk("arb no err", err[0], 0);

    // WAIT_CYCLES=3: rdy exactly 4 cycles after the request cycle.
    host_xfer(1, 1, 32'h4000_0008, 32'hCAFE_F00D, rd, ok);
    chk("w3 preload done", ok, 1);
    fab(1, 0, 32'h4000_0008, 0);
    step();
    txn_req[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w3 cyc%0d no rdy", 11 + k), txn_rdy[1], 0);
      chk($sformatf("w3 cyc%0d data0", 11 + k), txn_rdata[1], 0);
      step();
    end
    chk("w3 cyc14 rdy", txn_rdy[1], 1);
    chk("w3 cyc14 data", txn_rdata[1], 32'hCAFE_F00D);
    step();
    chk("w3 cyc15 idle", txn_rdy[1], 0);

    // txn_req while busy is dropped and flags err; the first request still completes.
    chk("w3 err before", err[1], 0);
    fab(1, 0, 32'h4000_0008, 0);
    step();
    fab(1, 0, 32'h4000_000C, 0);
    step();
    txn_req[1] = 1'b0;
    chk("w3 busy err", err[1], 1);
    step();
    step();
    chk("w3 busy rdy", txn_rdy[1], 1);
    chk("w3 busy data", txn_rdata[1], 32'hCAFE_F00D);
    step();
    chk("w3 dropped req", txn_rdy[1], 0);

    // WAIT_CYCLES=2: reset during WAIT aborts the response, write persists.
    fab(2, 1, 32'h4000_2000, 32'h0000_0005);
    step();
    txn_req[2] = 1'b0;
    arst = 1'b1;
    #2;
    arst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort cyc%0d no rdy", k), txn_rdy[2], 0);
      step();
    end
    host_xfer(2, 0, 32'h4000_2000, 0, rd, ok);
    chk("abort host done", ok, 1);
    chk("abort host data", rd, 32'h0000_0005);
    chk("abort no err", err[2], 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
